// File: rtl/risc_pkg.sv
// Shared definitions for the 32-bit, 12-bit-address RISC core: word sizes,
// opcode encodings and the opcode field position.
`timescale 1ns/1ps
package risc_pkg;

  localparam int WIDTH    = 32;
  localparam int ADDRSIZE = 12;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 28;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_BRA = 4'h1,
    OP_LD  = 4'h2,
    OP_STR = 4'h3,
    OP_ADD = 4'h4,
    OP_MUL = 4'h5,
    OP_CMP = 4'h6,
    OP_SHF = 4'h7,
    OP_ROT = 4'h8,
    OP_HLT = 4'h9,
    OP_XOR = 4'hA,
    OP_AND = 4'hB
  } opcode_t;

  function automatic logic is_hlt(input logic [WIDTH-1:0] word);
    return (word[OP_MSB:OP_LSB] == OP_HLT);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: memory read port, {ir, pc} output stream, branch
// redirect and halt status.
`timescale 1ns/1ps
interface instr_fetch_unit_if #(
  parameter int WIDTH    = risc_pkg::WIDTH,
  parameter int ADDRSIZE = risc_pkg::ADDRSIZE
);

  // Handshakes: a transfer happens in a cycle where both sides of the pair
  // are high at the rising edge (mem_req & mem_gnt, out_valid & out_ready);
  // the offering side holds its payload stable until then. mem_rvalid and
  // redirect_valid are single-cycle strobes with no back-pressure.
  logic                mem_req;
  logic [ADDRSIZE-1:0] mem_addr;
  logic                mem_gnt;
  logic                mem_rvalid;
  logic [WIDTH-1:0]    mem_rdata;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_ir;
  logic [ADDRSIZE-1:0] out_pc;
  logic                redirect_valid;
  logic [ADDRSIZE-1:0] redirect_pc;
  logic                halted;

  modport master (
    output mem_req, mem_addr, out_valid, out_ir, out_pc, halted,
    input  mem_gnt, mem_rvalid, mem_rdata, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_ir, out_pc, halted,
    output mem_gnt, mem_rvalid, mem_rdata, out_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, ir} pairs; clear empties it in one
// cycle. Storage is read combinationally at the head.
`timescale 1ns/1ps
module fetch_fifo #(
  parameter int W     = 44,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  store [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) store[wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: issues word reads, tracks in-flight requests,
// buffers {pc, ir} in a prefetch FIFO, and handles redirects and HLT.
`timescale 1ns/1ps
module instr_fetch_unit #(
  parameter int                           WIDTH    = risc_pkg::WIDTH,
  parameter int                           ADDRSIZE = risc_pkg::ADDRSIZE,
  parameter int                           DEPTH    = 4,
  parameter logic [risc_pkg::ADDRSIZE-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  instr_fetch_unit_if.master     bus
);
  import risc_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDRSIZE-1:0]       fetch_pc;
  logic [ADDRSIZE-1:0]       resp_pc;
  logic [CW-1:0]             outstanding;
  logic [CW-1:0]             discard_cnt;
  logic                      halt_seen;
  logic [CW-1:0]             fifo_count;
  logic [CW:0]               in_use;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      issue;
  logic                      rsp;
  logic                      keep;
  logic                      keep_hlt;
  logic                      pop;
  logic [ADDRSIZE+WIDTH-1:0] fifo_din;
  logic [ADDRSIZE+WIDTH-1:0] fifo_dout;

  // Entries plus in-flight requests never exceed DEPTH, so a response always
  // has a FIFO slot waiting for it.
  assign in_use       = {1'b0, fifo_count} + {1'b0, outstanding};
  assign bus.mem_req  = !reset && !bus.redirect_valid && !halt_seen &&
                        (in_use < (CW+1)'(DEPTH));
  assign bus.mem_addr = fetch_pc;
  assign issue        = bus.mem_req && bus.mem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp      = bus.mem_rvalid && (outstanding != '0);
  assign keep     = rsp && !bus.redirect_valid && (discard_cnt == '0);
  assign keep_hlt = keep && is_hlt(bus.mem_rdata);
  assign fifo_din = {resp_pc, bus.mem_rdata};

  assign bus.out_valid        = !fifo_empty;
  assign pop                  = bus.out_valid && bus.out_ready;
  assign {bus.out_pc, bus.out_ir} = fifo_dout;
  assign bus.halted           = halt_seen && fifo_empty && (outstanding == '0);

  fetch_fifo #(.W(ADDRSIZE + WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (keep),
    .pop   (pop),
    .clear (bus.redirect_valid),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
      halt_seen   <= 1'b0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(rsp);
      if (bus.redirect_valid) begin
        fetch_pc    <= bus.redirect_pc;
        resp_pc     <= bus.redirect_pc;
        discard_cnt <= outstanding - CW'(rsp);
        halt_seen   <= 1'b0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + ADDRSIZE'(1);
        if (keep)  resp_pc  <= resp_pc + ADDRSIZE'(1);
        // After HLT, drop every word still in flight, including one issued
        // in the same cycle the HLT arrives.
        if (keep_hlt) begin
          halt_seen   <= 1'b1;
          discard_cnt <= outstanding + CW'(issue) - CW'(1);
        end else if (rsp && (discard_cnt != '0)) begin
          discard_cnt <= discard_cnt - CW'(1);
        end
      end
    end
  end

  // Full is implied by the throttle; kept for observability.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order memory model of
// configurable latency and a {pc, ir} expected queue.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
  import risc_pkg::*;

  localparam int W = 32;
  localparam int A = 12;
  localparam int D = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  instr_fetch_unit_if #(.WIDTH(W), .ADDRSIZE(A)) bus ();

  instr_fetch_unit #(.WIDTH(W), .ADDRSIZE(A), .DEPTH(D), .RESET_PC(12'h000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // ---------------- memory model ----------------
  typedef struct {
    logic [A-1:0] addr;
    longint       due;
  } pend_t;

  logic [W-1:0] mem_array [0:4095];
  pend_t        pend_q[$];
  logic [A-1:0] issue_log[$];
  int           lat = 1;

  always @(negedge clk) begin
    #1;
    if (reset) begin
      pend_q.delete();
      issue_log.delete();
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
    end else begin
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = mem_array[pend_q[0].addr];
        pend_q.delete(0);
      end else begin
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
      end
      #1;
      if (bus.mem_req && bus.mem_gnt) begin
        pend_q.push_back('{addr: bus.mem_addr, due: cyc + longint'(lat)});
        issue_log.push_back(bus.mem_addr);
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [A+W-1:0] exp_q[$];
  longint         pop_cyc[$];
  longint         rel_cyc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [A-1:0] pc);
    exp_q.push_back({pc, mem_array[pc]});
  endtask

  always @(negedge clk) begin
    logic [A+W-1:0] e;
    #3;
    if (!reset && bus.out_valid && bus.out_ready) begin
      check("out_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_pc", 64'(bus.out_pc), 64'(e[A+W-1:W]));
        check("out_ir", 64'(bus.out_ir), 64'(e[W-1:0]));
        pop_cyc.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int l);
    @(negedge clk);
    reset = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    lat = l;
    repeat (2) @(negedge clk);
    exp_q.delete();
    pop_cyc.delete();
    reset = 1'b0;
    rel_cyc = cyc;
  endtask

  // Waits for the expected queue to empty, then drops out_ready before the
  // next handshake can happen.
  task automatic wait_drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    bus.out_ready = 1'b0;
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 4096; i++) mem_array[i] = {4'h0, 4'hA, 12'(i * 5), 12'(i)};
    bus.mem_gnt = 1'b1;
    bus.out_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #3;
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_halted", 64'(bus.halted), 64'd0);

    // Streaming, latency 1
    do_reset(1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) push_exp(12'(i));
    #3;
    check("first_mem_req", 64'(bus.mem_req), 64'd1);
    check("first_mem_addr", 64'(bus.mem_addr), 64'h000);
    wait_drain("stream_drain");
    if (pop_cyc.size() == 10) begin
      check("stream_first_lat", 64'(pop_cyc[0] - rel_cyc), 64'd2);
      check("stream_rate", 64'(pop_cyc[9] - pop_cyc[0]), 64'd9);
    end

    // Back-pressure, latency 2
    do_reset(2);
    repeat (10) @(negedge clk);
    #3;
    check("bp_issue_count", 64'(issue_log.size()), 64'd4);
    check("bp_mem_req", 64'(bus.mem_req), 64'd0);
    check("bp_out_valid", 64'(bus.out_valid), 64'd1);
    if (issue_log.size() >= 4) check("bp_last_addr", 64'(issue_log[3]), 64'h003);
    @(negedge clk);
    for (int i = 0; i < 8; i++) push_exp(12'(i));
    bus.out_ready = 1'b1;
    wait_drain("bp_drain");
    if (issue_log.size() >= 5) check("bp_resume_addr", 64'(issue_log[4]), 64'h004);

    // Redirect with 2 in FIFO and 2 in flight (one arriving this cycle)
    do_reset(4);
    repeat (6) @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 12'h100;
    #3;
    check("redir_pre_valid", 64'(bus.out_valid), 64'd1);
    check("redir_pre_pc", 64'(bus.out_pc), 64'h000);
    check("redir_mem_req", 64'(bus.mem_req), 64'd0);
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) push_exp(12'h100 + 12'(i));
    bus.out_ready = 1'b1;
    #3;
    check("redir_out_valid", 64'(bus.out_valid), 64'd0);
    check("redir_req", 64'(bus.mem_req), 64'd1);
    check("redir_addr", 64'(bus.mem_addr), 64'h100);
    wait_drain("redir_drain");

    // HLT at address 5, latency 3
    mem_array[5] = 32'h9000_0000;
    do_reset(3);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) push_exp(12'(i));
    wait_drain("hlt_drain");
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #3;
      if (bus.halted) break;
    end
    check("hlt_halted", 64'(bus.halted), 64'd1);
    check("hlt_out_valid", 64'(bus.out_valid), 64'd0);
    check("hlt_mem_req", 64'(bus.mem_req), 64'd0);
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 12'h000;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) push_exp(12'(i));
    bus.out_ready = 1'b1;
    #3;
    check("hlt_restart_halted", 64'(bus.halted), 64'd0);
    check("hlt_restart_req", 64'(bus.mem_req), 64'd1);
    check("hlt_restart_addr", 64'(bus.mem_addr), 64'h000);
    wait_drain("hlt_restart_drain");
    mem_array[5] = {4'h0, 4'hA, 12'(25), 12'(5)};

    // Address wrap via redirect to 0xFFE
    do_reset(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 12'hFFE;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    push_exp(12'hFFE);
    push_exp(12'hFFF);
    push_exp(12'h000);
    push_exp(12'h001);
    bus.out_ready = 1'b1;
    #3;
    check("wrap_addr", 64'(bus.mem_addr), 64'hFFE);
    wait_drain("wrap_drain");

    // Reset mid-operation: 3 entries buffered, 1 in flight
    do_reset(2);
    repeat (4) @(negedge clk);
    #3;
    check("midrst_pre_valid", 64'(bus.out_valid), 64'd1);
    check("midrst_pre_pc", 64'(bus.out_pc), 64'h000);
    @(negedge clk);
    reset = 1'b1;
    #3;
    check("midrst_mem_req", 64'(bus.mem_req), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    lat = 1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) push_exp(12'(i));
    bus.out_ready = 1'b1;
    #3;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_req", 64'(bus.mem_req), 64'd1);
    check("midrst_addr", 64'(bus.mem_addr), 64'h000);
    wait_drain("midrst_drain");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
